// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, runs a request/response handshake to instruction memory and
// presents one instruction per commit cycle, then computes the next PC from control inputs.
module instr_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              ALIGN_CHECK = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imemReqValid,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemReqReady,
  input  logic            imemRespValid,
  input  logic [31:0]     imemRespData,
  output logic [31:0]     instr,
  output logic            instrValid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  input  logic            isBranch,
  input  logic            branchTaken,
  input  logic            isJal,
  input  logic            isJalr,
  input  logic            halt,
  input  logic [XLEN-1:0] immOffset,
  input  logic [XLEN-1:0] rs1Value,
  output logic            halted,
  output logic            misaligned
);

  // state | meaning
  // REQ   | request pc from imem; accepted when imemReqValid & imemReqReady
  // WAIT  | request accepted, waiting for imemRespValid
  // EXEC  | commit cycle: instrValid=1, control inputs sampled, pc updated
  // HALT  | stopped by halt or misaligned target; only reset leaves

  typedef enum logic [1:0] {REQ, WAIT, EXEC, HALT} fetchStateT;

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] BIT0_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  fetchStateT      state;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] nextPc;
  logic            targetMisaligned;

  assign imemReqAddr = pc;
  assign pcPlus4     = pc + XLEN'(4);
  assign jalrSum     = rs1Value + immOffset;

  always_comb begin
    nextPc = pcPlus4;
    if (isJalr)
      nextPc = jalrSum & BIT0_MASK;
    else if (isJal || (isBranch && branchTaken))
      nextPc = pc + immOffset;
  end

  assign targetMisaligned = (ALIGN_CHECK != 0) && (nextPc[1:0] != 2'b00);

  // imemReqValid is registered, so REQ spends its first cycle after reset with the request
  // still low; a handshake only counts once the request is actually visible on the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      imemReqValid <= 1'b0;
      instrValid   <= 1'b0;
      halted       <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imemReqValid && imemReqReady) begin
            imemReqValid <= 1'b0;
            state        <= WAIT;
          end else begin
            imemReqValid <= 1'b1;
          end
        end
        WAIT: begin
          if (imemRespValid) begin
            instr      <= imemRespData;
            instrValid <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          instrValid <= 1'b0;
          if (halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (targetMisaligned) begin
            misaligned <= 1'b1;
            halted     <= 1'b1;
            state      <= HALT;
          end else begin
            pc           <= nextPc;
            imemReqValid <= 1'b1;
            state        <= REQ;
          end
        end
        HALT: begin
          imemReqValid <= 1'b0;
          instrValid   <= 1'b0;
          halted       <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: bench-driven imem handshake, hand-computed PCs.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        isBranch, branchTaken, isJal, isJalr, halt;
  logic [31:0] immOffset;
  logic [31:0] rs1Value;
  logic        halted;
  logic        misaligned;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instr(instr), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
    .isBranch(isBranch), .branchTaken(branchTaken), .isJal(isJal), .isJalr(isJalr),
    .halt(halt), .immOffset(immOffset), .rs1Value(rs1Value),
    .halted(halted), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, checks its address, accepts it, answers one cycle later
  // and checks the commit cycle. Returns at the negedge of the EXEC cycle.
  task automatic serve(input string tag, input logic [31:0] expAddr, input logic [31:0] word);
    int n = 0;
    while (imemReqValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " reqValid"}, {31'b0, imemReqValid}, 32'd1);
    check({tag, " reqAddr"}, imemReqAddr, expAddr);
    imemReqReady = 1'b1;
    @(negedge clk);
    imemReqReady  = 1'b0;
    imemRespValid = 1'b1;
    imemRespData  = word;
    @(negedge clk);
    imemRespValid = 1'b0;
    check({tag, " instrValid"}, {31'b0, instrValid}, 32'd1);
    check({tag, " instr"}, instr, word);
    check({tag, " pc"}, pc, expAddr);
  endtask

  task automatic execute(input logic br, input logic tk, input logic jal, input logic jalr,
                         input logic hlt, input logic [31:0] imm, input logic [31:0] rs1);
    isBranch = br; branchTaken = tk; isJal = jal; isJalr = jalr; halt = hlt;
    immOffset = imm; rs1Value = rs1;
    @(negedge clk);
    isBranch = 0; branchTaken = 0; isJal = 0; isJalr = 0; halt = 0;
    immOffset = '0; rs1Value = '0;
  endtask

  task automatic seq();
    execute(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; imemReqReady = 0; imemRespValid = 0; imemRespData = '0;
    isBranch = 0; branchTaken = 0; isJal = 0; isJalr = 0; halt = 0;
    immOffset = '0; rs1Value = '0;

    // 1: reset state and zero-wait first fetch
    repeat (3) @(negedge clk);
    check("rst reqValid", {31'b0, imemReqValid}, 32'd0);
    check("rst instrValid", {31'b0, instrValid}, 32'd0);
    check("rst halted", {31'b0, halted}, 32'd0);
    check("rst misaligned", {31'b0, misaligned}, 32'd0);
    check("rst pc", pc, 32'h0);
    check("rst instr", instr, NOP);
    imemReqReady = 1; reset = 0;
    @(negedge clk);
    check("t1 c1 reqValid", {31'b0, imemReqValid}, 32'd1);
    check("t1 c1 reqAddr", imemReqAddr, 32'h0);
    @(negedge clk);
    check("t1 c2 reqValid", {31'b0, imemReqValid}, 32'd0);
    check("t1 c2 instrValid", {31'b0, instrValid}, 32'd0);
    imemReqReady = 0; imemRespValid = 1; imemRespData = ADDI;
    @(negedge clk);
    imemRespValid = 0;
    check("t1 c3 instrValid", {31'b0, instrValid}, 32'd1);
    check("t1 c3 instr", instr, ADDI);
    check("t1 c3 pcPlus4", pcPlus4, 32'h4);
    @(negedge clk);
    check("t1 c4 instrValid", {31'b0, instrValid}, 32'd0);
    check("t1 c4 reqValid", {31'b0, imemReqValid}, 32'd1);
    check("t1 c4 reqAddr", imemReqAddr, 32'h4);

    // 2: branch taken backwards, then not taken
    serve("t2 a", 32'h4, NOP);  seq();
    serve("t2 b", 32'h8, NOP);  seq();
    serve("t2 c", 32'hC, NOP);  seq();
    serve("t2 d", 32'h10, NOP); execute(1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
    serve("t2 taken", 32'h8, NOP); seq();
    serve("t2 e", 32'hC, NOP);  seq();
    serve("t2 f", 32'h10, NOP); execute(1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);

    // 3: jalr (with jal also set, jalr wins), then misaligned jalr
    serve("t3 a", 32'h14, NOP); execute(0, 0, 1, 0, 0, 32'hC, 32'h0);
    serve("t3 b", 32'h20, NOP); execute(0, 0, 1, 1, 0, 32'h0, 32'h101);
    serve("t3 c", 32'h100, NOP); execute(0, 0, 0, 1, 0, 32'h0, 32'h103);
    check("t3 misaligned", {31'b0, misaligned}, 32'd1);
    check("t3 halted", {31'b0, halted}, 32'd1);
    check("t3 pc held", pc, 32'h100);
    imemReqReady = 1;
    for (int i = 0; i < 5; i++) begin
      check("t3 no req", {31'b0, imemReqValid}, 32'd0);
      @(negedge clk);
    end
    imemReqReady = 0;

    // 4: ready held low, responses in REQ ignored, delayed response
    reset = 1;
    @(negedge clk);
    check("t4 rst misaligned", {31'b0, misaligned}, 32'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    imemRespValid = 1; imemRespData = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("t4 reqValid held", {31'b0, imemReqValid}, 32'd1);
      check("t4 addr stable", imemReqAddr, 32'h0);
      check("t4 no commit", {31'b0, instrValid}, 32'd0);
      @(negedge clk);
    end
    imemRespValid = 0; imemReqReady = 1;
    @(negedge clk);
    imemReqReady = 0;
    for (int i = 0; i < 3; i++) begin
      check("t4 wait instrValid", {31'b0, instrValid}, 32'd0);
      check("t4 wait reqValid", {31'b0, imemReqValid}, 32'd0);
      @(negedge clk);
    end
    imemRespValid = 1; imemRespData = 32'h0020_0113;
    @(negedge clk);
    imemRespValid = 0;
    check("t4 instrValid", {31'b0, instrValid}, 32'd1);
    check("t4 instr", instr, 32'h0020_0113);
    seq();
    check("t4 single pulse", {31'b0, instrValid}, 32'd0);

    // 5: halt (priority over jal) at 0x40, then reset recovers
    serve("t5 a", 32'h4, NOP); execute(0, 0, 1, 0, 0, 32'h3C, 32'h0);
    serve("t5 b", 32'h40, NOP); execute(0, 0, 1, 0, 1, 32'h100, 32'h0);
    check("t5 halted", {31'b0, halted}, 32'd1);
    check("t5 misaligned", {31'b0, misaligned}, 32'd0);
    imemReqReady = 1; imemRespValid = 1; imemRespData = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      check("t5 no req", {31'b0, imemReqValid}, 32'd0);
      check("t5 no commit", {31'b0, instrValid}, 32'd0);
      check("t5 pc held", pc, 32'h40);
      check("t5 instr held", instr, NOP);
      @(negedge clk);
    end
    imemReqReady = 0; imemRespValid = 0;
    reset = 1;
    @(negedge clk);
    check("t5 rst reqValid", {31'b0, imemReqValid}, 32'd0);
    @(negedge clk);
    reset = 0;
    serve("t5 restart", 32'h0, NOP);
    check("t5 unhalted", {31'b0, halted}, 32'd0);

    // 6: PC wrap and jal
    execute(0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
    serve("t6 top", 32'hFFFF_FFFC, NOP);
    check("t6 pcPlus4 wrap", pcPlus4, 32'h0);
    seq();
    serve("t6 wrap", 32'h0, NOP); execute(0, 0, 1, 0, 0, 32'h8, 32'h0);
    serve("t6 at8", 32'h8, NOP); execute(0, 0, 1, 0, 0, 32'h7FC, 32'h0);
    serve("t6 jal", 32'h804, NOP); seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
